// File: rtl/zx_fdd_mailbox_ctrl_if.sv
// zx_fdd_mailbox_ctrl_if: ZX/FDD mailbox bus between the CPU-side glue and the controller.
// Strobes (async, active-high): zx_wr_stb, zx_rd_stb, fdd_wr_stb, fdd_rd_stb.
// Data in: zx_din, fdd_din (valid while the matching write strobe is high).
// Sync pulses: clr_z2f_err, clr_f2z_err.
// Outputs: fdd_dout (z2f mailbox), zx_dout (f2z mailbox), status, fdd_irq, zx_irq.
// master = CPU-side glue driving strobes; slave = the controller.
interface zx_fdd_mailbox_ctrl_if #(
    parameter int DW = 6
);
    logic          zx_wr_stb;
    logic          zx_rd_stb;
    logic [DW-1:0] zx_din;
    logic          fdd_wr_stb;
    logic          fdd_rd_stb;
    logic [DW-1:0] fdd_din;
    logic          clr_z2f_err;
    logic          clr_f2z_err;
    logic [DW-1:0] fdd_dout;
    logic [DW-1:0] zx_dout;
    logic [7:0]    status;
    logic          fdd_irq;
    logic          zx_irq;

    modport master (
        output zx_wr_stb, zx_rd_stb, zx_din, fdd_wr_stb, fdd_rd_stb, fdd_din,
        output clr_z2f_err, clr_f2z_err,
        input  fdd_dout, zx_dout, status, fdd_irq, zx_irq
    );

    modport slave (
        input  zx_wr_stb, zx_rd_stb, zx_din, fdd_wr_stb, fdd_rd_stb, fdd_din,
        input  clr_z2f_err, clr_f2z_err,
        output fdd_dout, zx_dout, status, fdd_irq, zx_irq
    );
endinterface

// File: rtl/zx_fdd_mailbox_ctrl.sv
// zx_fdd_mailbox_ctrl: single-word ZX<->FDD mailbox handshake controller in the 16MHz domain.
// Ports: CLK_16MHZ master clock; nRESET async active-low reset;
//        bus (slave modport) carries the async strobes, data lanes, error-clear pulses,
//        both mailbox outputs, the 8-bit status word and the two level irqs.
// status = {f2z_udr, f2z_ovr, f2z_stale, f2z_full, z2f_udr, z2f_ovr, z2f_stale, z2f_full}.

// zx_fdd_strobe_sync: retimes one async strobe and yields single-cycle rise/fall events.
// Ports: sync_ok marks that the synchroniser chains hold real samples since reset;
//        stb async strobe; rise/fall one-clock event pulses.
module zx_fdd_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK_16MHZ,
    input  logic nRESET,
    input  logic sync_ok,
    input  logic stb,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   armed;

    // armed only after a genuine low sample, so a strobe held high through reset
    // release never looks like a fresh edge
    always_ff @(posedge CLK_16MHZ or negedge nRESET) begin
        if (!nRESET) begin
            sync  <= '0;
            hist  <= 1'b0;
            armed <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], stb};
            hist  <= sync[SYNC_STAGES-1];
            armed <= armed | (sync_ok & ~sync[SYNC_STAGES-1]);
        end
    end

    assign rise = armed & sync[SYNC_STAGES-1] & ~hist;
    assign fall = armed & ~sync[SYNC_STAGES-1] & hist;
endmodule

// zx_fdd_mailbox_chan: one mailbox (EMPTY/FULL) with data latch, stale counter and sticky errors.
// Ports: wr write event; rd read-complete event; clr error-clear pulse; din producer data;
//        dout mailbox contents; full state; stale/ovr/udr sticky error flags.
module zx_fdd_mailbox_chan #(
    parameter int DW        = 6,
    parameter int STALE_CYC = 16000
) (
    input  logic          CLK_16MHZ,
    input  logic          nRESET,
    input  logic          wr,
    input  logic          rd,
    input  logic          clr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          stale,
    output logic          ovr,
    output logic          udr
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [15:0] LIMIT = 16'(STALE_CYC);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic        accept;
    logic        ovr_set;
    logic        udr_set;
    logic        stale_set;

    always_ff @(posedge CLK_16MHZ or negedge nRESET) begin
        if (!nRESET) state <= EMPTY;
        else         state <= state_nxt;
    end

    // a read completing alongside a write frees the slot first, so the write lands
    always_comb begin
        state_nxt = (state == EMPTY) ? (wr ? FULL : EMPTY) : ((rd && !wr) ? EMPTY : FULL);
    end

    always_comb begin
        full      = (state == FULL);
        accept    = wr && ((state == EMPTY) || rd);
        ovr_set   = wr && (state == FULL) && !rd;
        udr_set   = rd && (state == EMPTY);
        cnt_nxt   = ((state == EMPTY) || accept) ? 16'd0 : ((cnt == LIMIT) ? cnt : cnt + 16'd1);
        stale_set = (cnt_nxt == LIMIT);
    end

    // set beats a coincident clear so no error event is ever lost
    always_ff @(posedge CLK_16MHZ or negedge nRESET) begin
        if (!nRESET) begin
            dout  <= '0;
            cnt   <= '0;
            stale <= 1'b0;
            ovr   <= 1'b0;
            udr   <= 1'b0;
        end else begin
            dout  <= accept ? din : dout;
            cnt   <= cnt_nxt;
            stale <= stale_set | (stale & ~clr);
            ovr   <= ovr_set | (ovr & ~clr);
            udr   <= udr_set | (udr & ~clr);
        end
    end
endmodule

module zx_fdd_mailbox_ctrl #(
    parameter int DW          = 6,
    parameter int SYNC_STAGES = 2,
    parameter int STALE_CYC   = 16000
) (
    input logic                  CLK_16MHZ,
    input logic                  nRESET,
    zx_fdd_mailbox_ctrl_if.slave bus
);
    logic [SYNC_STAGES-1:0] vld_sr;
    logic                   zx_wr_ev;
    logic                   zx_rd_ev;
    logic                   fdd_wr_ev;
    logic                   fdd_rd_ev;
    logic                   zx_wr_fall;
    logic                   zx_rd_rise;
    logic                   fdd_wr_fall;
    logic                   fdd_rd_rise;
    logic                   z2f_full;
    logic                   z2f_stale;
    logic                   z2f_ovr;
    logic                   z2f_udr;
    logic                   f2z_full;
    logic                   f2z_stale;
    logic                   f2z_ovr;
    logic                   f2z_udr;

    // fills with ones after reset; once the last bit is set every synchroniser
    // output reflects a real sample of its strobe rather than its reset value
    always_ff @(posedge CLK_16MHZ or negedge nRESET) begin
        if (!nRESET) vld_sr <= '0;
        else         vld_sr <= {vld_sr[SYNC_STAGES-2:0], 1'b1};
    end

    zx_fdd_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_zx_wr (
        .CLK_16MHZ(CLK_16MHZ), .nRESET(nRESET), .sync_ok(vld_sr[SYNC_STAGES-1]),
        .stb(bus.zx_wr_stb), .rise(zx_wr_ev), .fall(zx_wr_fall)
    );

    zx_fdd_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_zx_rd (
        .CLK_16MHZ(CLK_16MHZ), .nRESET(nRESET), .sync_ok(vld_sr[SYNC_STAGES-1]),
        .stb(bus.zx_rd_stb), .rise(zx_rd_rise), .fall(zx_rd_ev)
    );

    zx_fdd_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fdd_wr (
        .CLK_16MHZ(CLK_16MHZ), .nRESET(nRESET), .sync_ok(vld_sr[SYNC_STAGES-1]),
        .stb(bus.fdd_wr_stb), .rise(fdd_wr_ev), .fall(fdd_wr_fall)
    );

    zx_fdd_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fdd_rd (
        .CLK_16MHZ(CLK_16MHZ), .nRESET(nRESET), .sync_ok(vld_sr[SYNC_STAGES-1]),
        .stb(bus.fdd_rd_stb), .rise(fdd_rd_rise), .fall(fdd_rd_ev)
    );

    zx_fdd_mailbox_chan #(.DW(DW), .STALE_CYC(STALE_CYC)) u_z2f (
        .CLK_16MHZ(CLK_16MHZ), .nRESET(nRESET),
        .wr(zx_wr_ev), .rd(fdd_rd_ev), .clr(bus.clr_z2f_err), .din(bus.zx_din),
        .dout(bus.fdd_dout), .full(z2f_full), .stale(z2f_stale), .ovr(z2f_ovr), .udr(z2f_udr)
    );

    zx_fdd_mailbox_chan #(.DW(DW), .STALE_CYC(STALE_CYC)) u_f2z (
        .CLK_16MHZ(CLK_16MHZ), .nRESET(nRESET),
        .wr(fdd_wr_ev), .rd(zx_rd_ev), .clr(bus.clr_f2z_err), .din(bus.fdd_din),
        .dout(bus.zx_dout), .full(f2z_full), .stale(f2z_stale), .ovr(f2z_ovr), .udr(f2z_udr)
    );

    assign bus.status  = {f2z_udr, f2z_ovr, f2z_stale, f2z_full, z2f_udr, z2f_ovr, z2f_stale, z2f_full};
    assign bus.fdd_irq = z2f_full;
    assign bus.zx_irq  = f2z_full;

    // the unused edge of each strobe is of no interest to the mailboxes
    logic unused_edges;
    assign unused_edges = zx_wr_fall ^ zx_rd_rise ^ fdd_wr_fall ^ fdd_rd_rise;
endmodule

// File: tb/tb_zx_fdd_mailbox_ctrl.sv
// tb_zx_fdd_mailbox_ctrl: randomized and directed bench for zx_fdd_mailbox_ctrl against a transaction-level mailbox model.
module tb_zx_fdd_mailbox_ctrl;
    localparam int S = 2;
    localparam int STALE = 100;
    localparam int ZW = 0, ZR = 1, FW = 2, FR = 3;

    logic clk = 1'b0;
    logic nRESET = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    zx_fdd_mailbox_ctrl_if #(.DW(6)) bus ();

    zx_fdd_mailbox_ctrl #(.DW(6), .SYNC_STAGES(S), .STALE_CYC(STALE)) dut (
        .CLK_16MHZ(clk),
        .nRESET(nRESET),
        .bus(bus)
    );

    logic [23:0] obs;
    assign obs = {bus.status, bus.fdd_dout, bus.zx_dout, bus.fdd_irq, bus.zx_irq};

    // mailbox model: index 0 = z2f, 1 = f2z; m_at is the cycle a mailbox became full
    bit       m_full[2];
    bit [5:0] m_data[2];
    bit       m_ovr[2];
    bit       m_udr[2];
    bit       m_stk[2];
    int       m_at[2];

    function automatic bit m_stale(input int c);
        return m_stk[c] || (m_full[c] && (cyc - m_at[c]) >= STALE);
    endfunction

    function automatic logic [23:0] exp_obs();
        return {m_udr[1], m_ovr[1], m_stale(1), m_full[1], m_udr[0], m_ovr[0], m_stale(0), m_full[0],
                m_data[0], m_data[1], m_full[0], m_full[1]};
    endfunction

    function automatic void m_reset();
        for (int c = 0; c < 2; c++) begin
            m_full[c] = 0; m_data[c] = '0; m_ovr[c] = 0; m_udr[c] = 0; m_stk[c] = 0; m_at[c] = 0;
        end
    endfunction

    function automatic void m_write(input int c, input bit [5:0] d);
        if (m_full[c]) m_ovr[c] = 1;
        else begin
            m_full[c] = 1; m_data[c] = d; m_at[c] = cyc;
        end
    endfunction

    function automatic void m_read(input int c);
        if (m_full[c]) begin
            m_stk[c] = m_stk[c] || ((cyc - m_at[c]) >= STALE);
            m_full[c] = 0;
        end else m_udr[c] = 1;
    endfunction

    function automatic void m_clr(input int c);
        m_ovr[c] = 0; m_udr[c] = 0; m_stk[c] = 0;
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_stb(input int w, input logic v);
        case (w)
            ZW: bus.zx_wr_stb = v;
            ZR: bus.zx_rd_stb = v;
            FW: bus.fdd_wr_stb = v;
            default: bus.fdd_rd_stb = v;
        endcase
    endtask

    task automatic stb_hi(input int w, input logic [5:0] d);
        @(negedge clk);
        set_stb(w, 1'b1);
        if (w == ZW) bus.zx_din = d;
        if (w == FW) bus.fdd_din = d;
    endtask

    task automatic stb_lo(input int w);
        @(negedge clk);
        set_stb(w, 1'b0);
        if (w == ZW) bus.zx_din = 6'($urandom);
        if (w == FW) bus.fdd_din = 6'($urandom);
    endtask

    task automatic full_op(input int w, input logic [5:0] d);
        stb_hi(w, d);
        wait_n(S + 1);
        if (w == ZW || w == FW) m_write((w == ZW) ? 0 : 1, d);
        wait_n(2);
        stb_lo(w);
        wait_n(S + 1);
        if (w == ZR || w == FR) m_read((w == FR) ? 0 : 1);
        wait_n(1);
    endtask

    task automatic clr_pulse(input int c);
        @(negedge clk);
        if (c == 0) bus.clr_z2f_err = 1'b1; else bus.clr_f2z_err = 1'b1;
        @(negedge clk);
        bus.clr_z2f_err = 1'b0;
        bus.clr_f2z_err = 1'b0;
        m_clr(c);
    endtask

    task automatic test_reset();
        wait_n(2);
        vectors++;
        if (obs !== 24'h0) begin miscompares++; $display("FAIL reset_vals obs=%h exp=%h", obs, 24'h0); end
        @(negedge clk);
        nRESET = 1'b1;
        m_reset();
        wait_n(20);
        vectors++;
        if (obs !== exp_obs()) begin miscompares++; $display("FAIL armed_ignore obs=%h exp=%h", obs, exp_obs()); end
        stb_lo(ZW);
        wait_n(S + 2);
        stb_hi(ZW, 6'h2A);
        wait_n(S);
        vectors++;
        if (bus.status[0] !== 1'b0) begin miscompares++; $display("FAIL z2f_full_early got=%b exp=0", bus.status[0]); end
        wait_n(1);
        m_write(0, 6'h2A);
        vectors++;
        if (bus.fdd_dout !== 6'h2A) begin miscompares++; $display("FAIL z2f_data got=%h exp=2a", bus.fdd_dout); end
        vectors++;
        if ({bus.status[0], bus.fdd_irq} !== 2'b11) begin miscompares++; $display("FAIL z2f_full got=%b exp=11", {bus.status[0], bus.fdd_irq}); end
        vectors++;
        if (obs !== exp_obs()) begin miscompares++; $display("FAIL z2f_first obs=%h exp=%h", obs, exp_obs()); end
        wait_n(2);
        stb_lo(ZW);
        wait_n(S + 2);
    endtask

    task automatic test_overrun();
        full_op(ZW, 6'h15);
        vectors++;
        if (bus.fdd_dout !== 6'h2A || bus.status[2] !== 1'b1) begin
            miscompares++; $display("FAIL z2f_ovr dout=%h ovr=%b exp dout=2a ovr=1", bus.fdd_dout, bus.status[2]);
        end
        stb_hi(FR, 6'h0);
        wait_n(S + 2);
        stb_lo(FR);
        wait_n(S);
        vectors++;
        if (bus.status[0] !== 1'b1) begin miscompares++; $display("FAIL z2f_empty_early got=%b exp=1", bus.status[0]); end
        wait_n(1);
        m_read(0);
        vectors++;
        if (bus.status[0] !== 1'b0 || bus.status[2] !== 1'b1) begin
            miscompares++; $display("FAIL z2f_read full=%b ovr=%b exp full=0 ovr=1", bus.status[0], bus.status[2]);
        end
        clr_pulse(0);
        vectors++;
        if (obs !== exp_obs() || bus.status[2] !== 1'b0) begin miscompares++; $display("FAIL z2f_clr obs=%h exp=%h", obs, exp_obs()); end
    endtask

    task automatic test_underrun();
        full_op(ZR, 6'h0);
        vectors++;
        if (bus.status[7] !== 1'b1 || bus.status[4] !== 1'b0) begin
            miscompares++; $display("FAIL f2z_udr udr=%b full=%b exp udr=1 full=0", bus.status[7], bus.status[4]);
        end
        stb_hi(ZR, 6'h0);
        wait_n(S + 2);
        stb_lo(ZR);
        wait_n(S);
        bus.clr_f2z_err = 1'b1;
        @(negedge clk);
        bus.clr_f2z_err = 1'b0;
        m_clr(1);
        m_read(1);
        vectors++;
        if (bus.status[7] !== 1'b1) begin miscompares++; $display("FAIL udr_set_beats_clr got=%b exp=1", bus.status[7]); end
        wait_n(1);
        clr_pulse(1);
        vectors++;
        if (obs !== exp_obs() || bus.status[7] !== 1'b0) begin miscompares++; $display("FAIL f2z_clr obs=%h exp=%h", obs, exp_obs()); end
    endtask

    task automatic test_aligned();
        full_op(FW, 6'h33);
        vectors++;
        if (bus.zx_dout !== 6'h33 || bus.status[4] !== 1'b1) begin
            miscompares++; $display("FAIL f2z_fill dout=%h full=%b exp dout=33 full=1", bus.zx_dout, bus.status[4]);
        end
        stb_hi(ZR, 6'h0);
        wait_n(S + 2);
        @(negedge clk);
        bus.zx_rd_stb = 1'b0;
        bus.fdd_wr_stb = 1'b1;
        bus.fdd_din = 6'h0C;
        wait_n(S);
        vectors++;
        if (bus.zx_dout !== 6'h33) begin miscompares++; $display("FAIL aligned_early got=%h exp=33", bus.zx_dout); end
        wait_n(1);
        m_data[1] = 6'h0C;
        m_at[1] = cyc;
        vectors++;
        if (bus.zx_dout !== 6'h0C || bus.status[4] !== 1'b1 || bus.status[6] !== 1'b0) begin
            miscompares++; $display("FAIL aligned dout=%h full=%b ovr=%b exp dout=0c full=1 ovr=0", bus.zx_dout, bus.status[4], bus.status[6]);
        end
        vectors++;
        if (obs !== exp_obs()) begin miscompares++; $display("FAIL aligned_all obs=%h exp=%h", obs, exp_obs()); end
        wait_n(2);
        stb_lo(FW);
        wait_n(S + 2);
        full_op(ZR, 6'h0);
        vectors++;
        if (obs !== exp_obs()) begin miscompares++; $display("FAIL aligned_drain obs=%h exp=%h", obs, exp_obs()); end
    endtask

    task automatic test_stale();
        stb_hi(FW, 6'h01);
        wait_n(S + 1);
        m_write(1, 6'h01);
        wait_n(2);
        stb_lo(FW);
        wait_n(S + 2);
        wait_n(STALE - 1 - (cyc - m_at[1]));
        vectors++;
        if (bus.status[5] !== 1'b0) begin miscompares++; $display("FAIL stale_early got=%b exp=0", bus.status[5]); end
        wait_n(1);
        vectors++;
        if (bus.status[5] !== 1'b1) begin miscompares++; $display("FAIL stale_set got=%b exp=1", bus.status[5]); end
        full_op(ZR, 6'h0);
        vectors++;
        if (bus.status[4] !== 1'b0 || bus.status[5] !== 1'b1) begin
            miscompares++; $display("FAIL stale_sticky full=%b stale=%b exp full=0 stale=1", bus.status[4], bus.status[5]);
        end
        clr_pulse(1);
        vectors++;
        if (bus.status !== 8'h00) begin miscompares++; $display("FAIL stale_clr got=%h exp=00", bus.status); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int op;
            op = $urandom_range(0, 5);
            if (op < 4) full_op(op, 6'($urandom));
            else clr_pulse(op - 4);
            wait_n($urandom_range(0, 40));
            vectors++;
            if (obs !== exp_obs()) begin miscompares++; $display("FAIL random op%0d kind=%0d obs=%h exp=%h", i, op, obs, exp_obs()); end
        end
    endtask

    task automatic test_async_reset();
        full_op(ZW, 6'($urandom_range(1, 63)));
        vectors++;
        if (bus.fdd_irq !== 1'b1) begin miscompares++; $display("FAIL pre_reset_full got=%b exp=1", bus.fdd_irq); end
        stb_hi(FW, 6'h3F);
        wait_n(1);
        #3;
        nRESET = 1'b0;
        #1;
        vectors++;
        if (obs !== 24'h0) begin miscompares++; $display("FAIL async_reset obs=%h exp=%h", obs, 24'h0); end
        set_stb(FW, 1'b0);
        wait_n(3);
        nRESET = 1'b1;
        m_reset();
        wait_n(S + 2);
        vectors++;
        if (obs !== exp_obs()) begin miscompares++; $display("FAIL post_reset obs=%h exp=%h", obs, exp_obs()); end
        full_op(FW, 6'h2A);
        vectors++;
        if (obs !== exp_obs()) begin miscompares++; $display("FAIL post_reset_write obs=%h exp=%h", obs, exp_obs()); end
    endtask

    initial begin
        bus.zx_wr_stb = 1'b1;
        bus.zx_rd_stb = 1'b0;
        bus.fdd_wr_stb = 1'b0;
        bus.fdd_rd_stb = 1'b0;
        bus.zx_din = '0;
        bus.fdd_din = '0;
        bus.clr_z2f_err = 1'b0;
        bus.clr_f2z_err = 1'b0;
        m_reset();
        test_reset();
        test_overrun();
        test_underrun();
        test_aligned();
        test_stale();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/zx_fdd_mailbox_ctrl.md
Name: zx_fdd_mailbox_ctrl

Overview:
- Synchronous handshake controller for the two single-word ZX↔FDD transfer latches in the interface CPLD.
- Retimes the asynchronous ZX I/O strobes and FDD TIIN/TIOUT strobes into the 16MHz domain, then owns both mailbox registers.
- Sequences each mailbox through EMPTY/FULL.
- Flags overrun, underrun and stale (unread too long) conditions so both CPUs can poll status instead of relying on timing.

Parameters:
- DW, 6: mailbox data width (D0,D1,D4-D7 lanes).
- SYNC_STAGES, 2: synchroniser flops per async strobe (legal 2..3).
- STALE_CYC, 16000: CLK_16MHZ cycles a mailbox may stay FULL before stale sets (1ms). Legal 1..65535.

Ports:
- CLK_16MHZ  in  1  master clock.
- nRESET  in  1  asynchronous active-low reset.
- zx_wr_stb  in  1  async, active-high; decoded ZX I/O write to data port.
- zx_rd_stb  in  1  async, active-high; decoded ZX I/O read of data port.
- zx_din  in  DW  ZX data lanes, valid while zx_wr_stb high.
- fdd_wr_stb  in  1  async, active-high; inverted nTIOUT.
- fdd_rd_stb  in  1  async, active-high; inverted nTIIN.
- fdd_din  in  DW  FDD data lanes, valid while fdd_wr_stb high.
- clr_z2f_err  in  1  sync pulse; clears z2f ovr/udr/stale.
- clr_f2z_err  in  1  sync pulse; clears f2z ovr/udr/stale.
- fdd_dout  out  DW  z2f mailbox contents.
- zx_dout  out  DW  f2z mailbox contents.
- status  out  8  {f2z_udr,f2z_ovr,f2z_stale,f2z_full, z2f_udr,z2f_ovr,z2f_stale,z2f_full}.
- fdd_irq  out  1  level; equals z2f_full.
- zx_irq  out  1  level; equals f2z_full.

Behaviour:
- Reset (async, nRESET low):
  - Immediately: all sync flops 0; both mailboxes EMPTY; data 0; all status bits 0; irqs 0; stale counters 0.
  - Each strobe has an "armed" bit, reset 0, set only once that strobe is seen low after synchronisation. Edges are ignored while unarmed, so a strobe already high at reset release is never taken as an event.
- Strobe handling:
  - Each strobe passes through SYNC_STAGES flops plus one history flop.
  - Write event = synchronised rising edge.
  - Read-complete event = synchronised falling edge. Data must stay stable for the whole CPU read, so the mailbox empties only after the read ends.
  - Strobes must remain high ≥ SYNC_STAGES+2 clocks (Z80 I/O cycles satisfy this).
- Data capture: on the write-event cycle, din is sampled directly; it is quasi-static while the strobe is high. Data registers change only on an accepted write.
- Per-mailbox FSM (z2f: producer ZX, consumer FDD; f2z: producer FDD, consumer ZX):
  - EMPTY + write → latch data, FULL.
  - EMPTY + read-complete → udr=1, stay EMPTY.
  - EMPTY + write + read-complete in the same cycle → latch data, FULL, udr=1.
  - FULL + write → data unchanged (write dropped), ovr=1.
  - FULL + read-complete → EMPTY.
  - FULL + write + read-complete in the same cycle → read completes first, then write latches new data; stays FULL, no ovr.
- Latency: full rises on clock SYNC_STAGES+1 after the first CLK_16MHZ edge that samples the strobe high. full falls SYNC_STAGES+1 clocks after the edge that samples the read strobe low. fdd_dout/zx_dout update on the same clock full rises.
- Stale counter (16-bit, per mailbox):
  - Cleared whenever the mailbox is EMPTY or a new write is accepted.
  - Increments each clock while FULL and saturates at STALE_CYC.
  - Reaching STALE_CYC sets stale.
- Error flags (ovr, udr, stale) are sticky and clear only on the matching clr_* pulse. If a set event and clr coincide, set wins (the flag stays 1).
- full is never cleared by clr_*.
- Status and irqs are registered: no combinational path from any async input to an output.

Test Plan:
- Reset with zx_wr_stb held high, release, keep high 20 clocks → no capture, z2f_full=0. Then drop and re-raise with zx_din=6'h2A → at SYNC_STAGES+1 clocks: fdd_dout=6'h2A, status[0]=1, fdd_irq=1.
- z2f FULL (6'h2A), second ZX write with 6'h15 → fdd_dout stays 6'h2A, status[2] (z2f_ovr)=1. Then a full fdd_rd_stb pulse → status[0]=0 at SYNC_STAGES+1 clocks after falling edge; status[2] stays 1 until clr_z2f_err.
- f2z EMPTY, zx_rd_stb pulse → status[7] (f2z_udr)=1, status[4]=0. clr_f2z_err asserted in the same cycle as a fresh udr event → status[7] remains 1.
- f2z FULL (6'h33), fdd write 6'h0C aligned so its synchronised rising edge coincides with the ZX read-complete edge → zx_dout=6'h0C, f2z_full stays 1, f2z_ovr=0.
- STALE_CYC=100, FDD writes 6'h01 and nobody reads → status[5]=1 exactly 100 clocks after f2z_full rises. Then a ZX read → full=0 with stale sticky; clr_f2z_err → status=0.
- Assert nRESET mid-pulse during a FULL mailbox → all outputs 0 asynchronously, before the next clock edge.
